// File: rtl/dmem_access_ctrl.sv
// rtl/dmem_access_ctrl.sv - MEM-stage data-memory access sequencer with req/ack handshake, stall and error flags
module dmem_access_ctrl #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mm2reg,
  input  logic        mwmem,
  input  logic [31:0] malu_out,
  input  logic [31:0] mqb,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        mem_stall,
  output logic [31:0] mmo,
  output logic        mem_valid,
  output logic        mem_err
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE, ERR} state_t;

  state_t           state;
  state_t           state_nx;
  logic [CNT_W-1:0] cnt;
  logic             op;
  logic             aligned;
  logic             timeout_hit;

  assign op          = mm2reg | mwmem;
  assign aligned     = (malu_out[1:0] == 2'b00);
  assign timeout_hit = (cnt == CNT_W'(TIMEOUT - 1));

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state decode and the combinational pipeline stall
  always_comb begin
    state_nx  = state;
    mem_stall = 1'b0;
    case (state)
      IDLE: begin
        if (op) begin
          mem_stall = 1'b1;
          state_nx  = aligned ? ACCESS : ERR;
        end
      end
      ACCESS: begin
        mem_stall = 1'b1;
        if (dmem_ack)         state_nx = DONE;
        else if (timeout_hit) state_nx = ERR;
      end
      DONE: begin
        // Pipeline advances at the end of this cycle
        state_nx = IDLE;
      end
      ERR: begin
        mem_stall = 1'b1;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Request/data registers, timeout counter and status flags
  always_ff @(posedge clk) begin
    if (rst) begin
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= 32'd0;
      dmem_wdata <= 32'd0;
      mmo        <= 32'd0;
      mem_valid  <= 1'b0;
      mem_err    <= 1'b0;
      cnt        <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (op && aligned) begin
            // Store wins when both load and store are flagged
            dmem_req   <= 1'b1;
            dmem_we    <= mwmem;
            dmem_addr  <= malu_out;
            dmem_wdata <= mqb;
            cnt        <= '0;
          end else if (op) begin
            mem_err <= 1'b1;
          end
        end
        ACCESS: begin
          if (dmem_ack) begin
            // Ack on the last count cycle still completes cleanly
            dmem_req  <= 1'b0;
            mem_valid <= 1'b1;
            if (!dmem_we) mmo <= dmem_rdata;
          end else if (timeout_hit) begin
            dmem_req <= 1'b0;
            mem_err  <= 1'b1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        DONE: begin
          mem_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// tb/tb_dmem_access_ctrl.sv - table-driven self-checking bench for dmem_access_ctrl
module tb_dmem_access_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mm2reg = 1'b0;
  logic        mwmem = 1'b0;
  logic [31:0] malu_out = 32'd0;
  logic [31:0] mqb = 32'd0;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic        dmem_ack = 1'b0;
  logic [31:0] dmem_rdata = 32'd0;
  logic        mem_stall;
  logic [31:0] mmo;
  logic        mem_valid;
  logic        mem_err;

  int checks = 0;
  int failures = 0;

  dmem_access_ctrl #(.TIMEOUT(16), .CNT_W(5)) dut (
    .clk(clk), .rst(rst), .mm2reg(mm2reg), .mwmem(mwmem),
    .malu_out(malu_out), .mqb(mqb), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack),
    .dmem_rdata(dmem_rdata), .mem_stall(mem_stall), .mmo(mmo),
    .mem_valid(mem_valid), .mem_err(mem_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        m2r, mw;
    logic [31:0] addr, qb;
    logic        ack;
    logic [31:0] rdata;
    logic        stall, req, we, valid, err;
    logic [31:0] eaddr, ewdata, emmo;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic m2r, logic mw, logic [31:0] addr, logic [31:0] qb,
                              logic ack, logic [31:0] rdata, logic stall, logic req,
                              logic we, logic valid, logic err, logic [31:0] eaddr,
                              logic [31:0] ewdata, logic [31:0] emmo);
    vec_t v;
    v.m2r = m2r; v.mw = mw; v.addr = addr; v.qb = qb; v.ack = ack; v.rdata = rdata;
    v.stall = stall; v.req = req; v.we = we; v.valid = valid; v.err = err;
    v.eaddr = eaddr; v.ewdata = ewdata; v.emmo = emmo;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input logic m2r, input logic mw, input logic [31:0] addr,
                       input logic [31:0] qb, input logic ack, input logic [31:0] rdata);
    mm2reg = m2r; mwmem = mw; malu_out = addr; mqb = qb; dmem_ack = ack; dmem_rdata = rdata;
  endtask

  task automatic next_cycle;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0);
    next_cycle();
    next_cycle();
    rst = 1'b0;
  endtask

  localparam logic [31:0] D = 32'hDEADBEEF;
  localparam logic [31:0] P = 32'h01020304;

  initial begin
    int reqs;

    // lw 0x10 quick ack, sw 0x20 with 3 wait cycles and changing inputs,
    // spurious ack in IDLE, lw+sw together, back-to-back lw/sw/lw
    tbl.push_back(mk(0,0,0,0,0,0,                     0,0,0,0,0, 0,0,0));
    tbl.push_back(mk(1,0,'h10,0,0,0,                  1,0,0,0,0, 0,0,0));
    tbl.push_back(mk(1,0,'h10,0,1,D,                  1,1,0,0,0, 'h10,0,0));
    tbl.push_back(mk(1,0,'h10,0,0,0,                  0,0,0,1,0, 0,0,D));
    tbl.push_back(mk(0,0,0,0,0,0,                     0,0,0,0,0, 0,0,D));
    tbl.push_back(mk(0,1,'h20,'h12345678,0,0,         1,0,0,0,0, 0,0,D));
    tbl.push_back(mk(0,1,'h20,'h12345678,0,0,         1,1,1,0,0, 'h20,'h12345678,D));
    tbl.push_back(mk(0,1,'h44,'hFFFFFFFF,0,0,         1,1,1,0,0, 'h20,'h12345678,D));
    tbl.push_back(mk(0,1,'h44,'hFFFFFFFF,0,0,         1,1,1,0,0, 'h20,'h12345678,D));
    tbl.push_back(mk(0,1,'h44,'hFFFFFFFF,1,'hCAFE,    1,1,1,0,0, 'h20,'h12345678,D));
    tbl.push_back(mk(0,1,'h44,'hFFFFFFFF,0,0,         0,0,1,1,0, 0,0,D));
    tbl.push_back(mk(0,0,0,0,1,'h77,                  0,0,1,0,0, 0,0,D));
    tbl.push_back(mk(1,1,'h30,'hA5A5A5A5,0,0,         1,0,1,0,0, 0,0,D));
    tbl.push_back(mk(1,1,'h30,'hA5A5A5A5,1,'h11111111,1,1,1,0,0, 'h30,'hA5A5A5A5,D));
    tbl.push_back(mk(1,1,'h30,'hA5A5A5A5,0,0,         0,0,1,1,0, 0,0,D));
    tbl.push_back(mk(0,0,0,0,0,0,                     0,0,1,0,0, 0,0,D));
    tbl.push_back(mk(1,0,'h40,0,0,0,                  1,0,1,0,0, 0,0,D));
    tbl.push_back(mk(1,0,'h40,0,1,P,                  1,1,0,0,0, 'h40,0,D));
    tbl.push_back(mk(0,1,'h44,'h0BADF00D,0,0,         0,0,0,1,0, 0,0,P));
    tbl.push_back(mk(0,1,'h44,'h0BADF00D,0,0,         1,0,0,0,0, 0,0,P));
    tbl.push_back(mk(0,1,'h44,'h0BADF00D,1,'h99,      1,1,1,0,0, 'h44,'h0BADF00D,P));
    tbl.push_back(mk(1,0,'h48,0,0,0,                  0,0,1,1,0, 0,0,P));
    tbl.push_back(mk(1,0,'h48,0,0,0,                  1,0,1,0,0, 0,0,P));
    tbl.push_back(mk(1,0,'h48,0,1,'h55,               1,1,0,0,0, 'h48,0,P));
    tbl.push_back(mk(0,0,0,0,0,0,                     0,0,0,1,0, 0,0,'h55));
    tbl.push_back(mk(0,0,0,0,0,0,                     0,0,0,0,0, 0,0,'h55));

    do_reset();
    @(negedge clk);
    chk("reset_req", dmem_req, 0);
    chk("reset_we", dmem_we, 0);
    chk("reset_addr", dmem_addr, 0);
    chk("reset_wdata", dmem_wdata, 0);
    chk("reset_mmo", mmo, 0);
    chk("reset_valid", mem_valid, 0);
    chk("reset_err", mem_err, 0);
    chk("reset_stall", mem_stall, 0);
    next_cycle();

    foreach (tbl[i]) begin
      drive(tbl[i].m2r, tbl[i].mw, tbl[i].addr, tbl[i].qb, tbl[i].ack, tbl[i].rdata);
      @(negedge clk);
      chk($sformatf("v%0d_stall", i), mem_stall, tbl[i].stall);
      chk($sformatf("v%0d_req", i), dmem_req, tbl[i].req);
      chk($sformatf("v%0d_we", i), dmem_we, tbl[i].we);
      chk($sformatf("v%0d_valid", i), mem_valid, tbl[i].valid);
      chk($sformatf("v%0d_err", i), mem_err, tbl[i].err);
      chk($sformatf("v%0d_mmo", i), mmo, tbl[i].emmo);
      if (tbl[i].req) chk($sformatf("v%0d_addr", i), dmem_addr, tbl[i].eaddr);
      if (tbl[i].req && tbl[i].we) chk($sformatf("v%0d_wdata", i), dmem_wdata, tbl[i].ewdata);
      next_cycle();
    end

    // Timeout: 16 ACCESS cycles without ack -> ERR, sticky until reset
    do_reset();
    drive(1, 0, 'h10, 0, 0, 0);
    next_cycle();
    reqs = 0;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      if (dmem_req) reqs++;
      next_cycle();
    end
    chk("to_req_cycles", reqs, 16);
    @(negedge clk);
    chk("to_req_drop", dmem_req, 0);
    chk("to_err", mem_err, 1);
    chk("to_stall", mem_stall, 1);
    next_cycle();
    drive(0, 0, 0, 0, 1, 'h1234);
    next_cycle();
    @(negedge clk);
    chk("to_err_sticky", mem_err, 1);
    chk("to_late_ack_valid", mem_valid, 0);
    chk("to_stall_stuck", mem_stall, 1);
    chk("to_mmo", mmo, 0);
    next_cycle();

    // Ack on the 16th ACCESS cycle wins over timeout
    do_reset();
    drive(1, 0, 'h10, 0, 0, 0);
    next_cycle();
    for (int k = 0; k < 15; k++) next_cycle();
    drive(1, 0, 'h10, 0, 1, 'hA0A0A0A0);
    @(negedge clk);
    chk("ack16_req", dmem_req, 1);
    next_cycle();
    drive(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("ack16_valid", mem_valid, 1);
    chk("ack16_err", mem_err, 0);
    chk("ack16_mmo", mmo, 'hA0A0A0A0);
    chk("ack16_stall", mem_stall, 0);
    next_cycle();

    // Misaligned load -> ERR, no request ever issued
    do_reset();
    drive(1, 0, 'h13, 0, 0, 0);
    @(negedge clk);
    chk("mis_stall_idle", mem_stall, 1);
    next_cycle();
    drive(0, 0, 0, 0, 1, 0);
    reqs = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (dmem_req) reqs++;
      next_cycle();
    end
    @(negedge clk);
    chk("mis_req_never", reqs, 0);
    chk("mis_err", mem_err, 1);
    chk("mis_stall_stuck", mem_stall, 1);
    next_cycle();

    // Reset during ACCESS, ack arrives afterwards and is ignored
    do_reset();
    drive(1, 0, 'h10, 0, 0, 0);
    next_cycle();
    @(negedge clk);
    chk("rstacc_req", dmem_req, 1);
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    drive(0, 0, 0, 0, 1, 'hBEEF);
    @(negedge clk);
    chk("rstacc_req_drop", dmem_req, 0);
    chk("rstacc_stall", mem_stall, 0);
    chk("rstacc_addr", dmem_addr, 0);
    next_cycle();
    drive(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("rstacc_valid", mem_valid, 0);
    chk("rstacc_mmo", mmo, 0);
    chk("rstacc_err", mem_err, 0);
    next_cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
